// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// FSM state encoding and the signed-overflow helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Two's-complement overflow from operand and result sign bits
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell.
// count is the carry-out of in_1 + in_2 + cin.
module full_adder (
    input  logic in_1,
    input  logic in_2,
    input  logic cin,
    output logic sum,
    output logic count
);

    assign sum   = in_1 ^ in_2 ^ cin;
    assign count = (in_1 & in_2) | (in_1 & cin) | (in_2 & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first.
// Optional SERIAL_ADDER_OVF_EN adds the signed overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             count,
    output logic             ovf
`else
    output logic             count
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             count_q, count_d;
    logic             fa_sum;
    logic             fa_count;
    logic             last_bit;
    logic [WIDTH-1:0] result;

`ifdef SERIAL_ADDER_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    full_adder u_fa (
        .in_1  (shift_a_q[0]),
        .in_2  (shift_b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .count (fa_count)
    );

    assign last_bit = (bit_cnt_q == LAST);
    assign result   = {fa_sum, acc_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: load on accept, shift one bit per SHIFT cycle
    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        sum_d     = sum_q;
        count_d   = count_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        if (state_q == ST_IDLE && start) begin
            shift_a_d = in_a;
            shift_b_d = in_b;
            carry_d   = cin;
            bit_cnt_d = '0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_d   = in_a[WIDTH-1];
            b_msb_d   = in_b[WIDTH-1];
`endif
        end else if (state_q == ST_SHIFT) begin
            shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
            shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
            acc_d     = result;
            carry_d   = fa_count;
            if (last_bit) begin
                sum_d   = result;
                count_d = fa_count;
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d   = signed_ovf(a_msb_q, b_msb_q,
                                     result[WIDTH-1]);
`endif
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Datapath and result registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
            sum_q     <= '0;
            count_q   <= 1'b0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            bit_cnt_q <= bit_cnt_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Captured operand sign bits and overflow result
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum   = sum_q;
    assign count = count_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Expected results are queued at issue and popped on done.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         count;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    serial_adder #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .in_a      (in_a),
        .in_b      (in_b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .count     (count),
        .ovf       (ovf)
`else
        .count     (count)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic c);
        exp_t e;
        e.res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy && !done) begin
                ok = 1'b1;
                return;
            end
            @(negedge sys_clk);
        end
    endtask

    // Issue one operation and wait (bounded) for its done pulse
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output int lat,
                         output int busy_n, output bit ok);
        bit idle_ok;
        lat = 0;
        busy_n = 0;
        ok = 1'b0;
        wait_idle(idle_ok);
        if (!idle_ok) return;
        in_a = a;
        in_b = b;
        cin = c;
        start = 1'b1;
        exp_q.push_back(model(a, b, c));
        for (int n = 1; n <= 4 * W; n++) begin
            @(negedge sys_clk);
            start = 1'b0;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            cin = 1'($urandom);
            if (busy) busy_n++;
            if (done) begin
                lat = n - 1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({busy, done, count, sum} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b count=%b sum=%h want all 0",
                     busy, done, count, sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_basic();
        int lat, bn;
        bit ok;
        exp_t e;
        do_op(8'h03, 8'h05, 1'b0, lat, bn, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: no done pulse");
            exp_q.delete();
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({count, sum} !== e.res || e.res !== 9'h008) begin
            errors++;
            $display("FAIL basic_sum: got %h want %h", {count, sum}, e.res);
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", lat, W);
        end
        checks++;
        if (bn !== W) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d want %0d", bn, W);
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        logic         tc[2];
        int lat, bn;
        bit ok;
        exp_t e;
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hFF; tb[1] = 8'h00; tc[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], tc[i], lat, bn, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL carry_timeout[%0d]: no done", i);
                exp_q.delete();
                continue;
            end
            e = exp_q.pop_front();
            checks++;
            if ({count, sum} !== 9'h100 || e.res !== 9'h100) begin
                errors++;
                $display("FAIL carry_sum[%0d]: got %h want 100", i, {count, sum});
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int dones = 0;
        int last_t = -1;
        exp_t e;
        wait_idle(ok);
        start = 1'b1;
        for (int t = 0; t < 200 && dones < 3; t++) begin
            if (!busy && !done) begin
                in_a = 8'h10;
                in_b = 8'h20;
                cin = 1'b0;
                exp_q.push_back(model(8'h10, 8'h20, 1'b0));
            end else begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                cin = 1'($urandom);
            end
            @(negedge sys_clk);
            if (done) begin
                dones++;
                if (dones == 3) start = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_queue: done with no pending op");
                end else begin
                    e = exp_q.pop_front();
                    if ({count, sum} !== e.res || sum !== 8'h30) begin
                        errors++;
                        $display("FAIL b2b_sum: got %h want %h", {count, sum}, e.res);
                    end
                end
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t !== W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d want %0d",
                                 t - last_t, W + 2);
                    end
                end
                last_t = t;
            end
        end
        start = 1'b0;
        checks++;
        if (dones !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d pending=%0d want 3/0",
                     dones, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit saw_done = 1'b0;
        int lat, bn;
        exp_t e;
        wait_idle(ok);
        in_a = 8'hC3;
        in_b = 8'h3C;
        cin = 1'b1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, count, sum} !== '0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b done=%b count=%b sum=%h want 0",
                     busy, done, count, sum);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            if (done) saw_done = 1'b1;
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        do_op(8'h01, 8'h01, 1'b0, lat, bn, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_after_timeout: no done");
            exp_q.delete();
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if ({count, sum} !== e.res || sum !== 8'h02) begin
            errors++;
            $display("FAIL abort_after_sum: got %h want 002", {count, sum});
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic [W:0]   ts[3];
        logic         tv[3];
        int lat, bn;
        bit ok;
        exp_t e;
        ta[0] = 8'h7F; tb[0] = 8'h01; ts[0] = 9'h080; tv[0] = 1'b1;
        ta[1] = 8'h80; tb[1] = 8'hFF; ts[1] = 9'h17F; tv[1] = 1'b1;
        ta[2] = 8'h01; tb[2] = 8'h01; ts[2] = 9'h002; tv[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, lat, bn, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL ovf_timeout[%0d]: no done", i);
                exp_q.delete();
                continue;
            end
            e = exp_q.pop_front();
            checks++;
            if ({count, sum} !== ts[i] || ovf !== tv[i] || e.ovf !== tv[i]) begin
                errors++;
                $display("FAIL ovf_case[%0d]: got %h ovf=%b want %h ovf=%b",
                         i, {count, sum}, ovf, ts[i], tv[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int lat, bn;
        bit ok;
        exp_t e;
        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), lat, bn, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_timeout[%0d]: no done", i);
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            if ({count, sum} !== e.res) begin
                errors++;
                $display("FAIL rand_sum[%0d]: got %h want %h", i, {count, sum}, e.res);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (ovf !== e.ovf) begin
                errors++;
                $display("FAIL rand_ovf[%0d]: got %b want %b", i, ovf, e.ovf);
            end
`endif
        end
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_abort();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
